// File: rtl/soc_encryption.sv
// soc_encryption: memory-mapped Ascon-128 (v1.2) AEAD encryption peripheral.
// The CPU writes key/nonce/AD/PT one byte per lane per write, starts a run,
// polls the ready flag, then streams {CT, tag} out one byte per clock.
// Ports:
//   clk                  rising-edge clock
//   rst                  asynchronous active-low reset
//   reg_inputxSS[3:0]    byte write strobes: bit0 key, bit1 nonce, bit2 AD, bit3 PT
//   inputxSI[31:0]       write data: [7:0] key, [15:8] nonce, [23:16] AD, [31:24] PT
//   reg_startxSS         start-register select
//   encryption_startxSI  start value (acts only with reg_startxSS)
//   reg_readyxSS         status-read select, no side effects
//   encryption_readyxSO  done flag, held until reset or next start
//   reg_outxSS           output-load select
//   cipher_tagxSO        output byte stream: CT MSB first, then tag MSB first
module soc_encryption #(
    parameter int unsigned k = 128,
    parameter int unsigned r = 64,
    parameter int unsigned a = 12,
    parameter int unsigned b = 6,
    parameter int unsigned l = 64,
    parameter int unsigned y = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  reg_inputxSS,
    input  logic [31:0] inputxSI,
    input  logic        reg_startxSS,
    input  logic        encryption_startxSI,
    input  logic        reg_readyxSS,
    output logic        encryption_readyxSO,
    input  logic        reg_outxSS,
    output logic [7:0]  cipher_tagxSO
);

    localparam int unsigned KEYN   = k / 8;
    localparam int unsigned NONCEN = 16;
    localparam int unsigned ADN    = l / 8;
    localparam int unsigned PTN    = y / 8;
    // Padding always adds at least one byte, so block count is floor(len/64)+1.
    localparam int unsigned ADBLK  = l / 64 + 1;
    localparam int unsigned PTBLK  = y / 64 + 1;
    localparam int unsigned ADW    = ADBLK * 64;
    localparam int unsigned PTW    = PTBLK * 64;
    localparam int unsigned OUTW   = y + 128;
    localparam logic [63:0] IV     = {8'(k), 8'(r), 8'(a), 8'(b), 32'h0};

    function automatic logic [63:0] rotr(input logic [63:0] v, input int unsigned n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // One Ascon permutation round: constant addition, S-box, linear layer.
    function automatic logic [319:0] asconRound(input logic [319:0] sIn, input logic [7:0] rc);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        x0 = sIn[319:256];
        x1 = sIn[255:192];
        x2 = sIn[191:128];
        x3 = sIn[127:64];
        x4 = sIn[63:0];
        x2 = x2 ^ {56'h0, rc};
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        x0 = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
        x1 = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
        x2 = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
        x3 = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
        x4 = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    typedef enum logic [2:0] {IDLE, INIT, AD, PT, FINAL, DONE} state_t;

    state_t           state;
    logic [k-1:0]     keyReg;
    logic [127:0]     nonceReg;
    logic [l-1:0]     adReg;
    logic [y-1:0]     ptReg;
    logic [15:0]      keyCnt, nonceCnt, adCnt, ptCnt;
    logic [319:0]     s;
    logic [3:0]       rnd;
    logic [15:0]      blk;
    logic [PTW-1:0]   ctBuf;
    logic [127:0]     tagReg;
    logic [OUTW-1:0]  outSr;
    logic             startPrev;

    logic             startReq, startPulse;
    logic [ADW-1:0]   adPad;
    logic [PTW-1:0]   ptPad;
    logic [63:0]      adBlk, ptBlk;
    logic [3:0]       rcIdx;
    logic [7:0]       rc;
    logic [319:0]     roundIn, roundOut;
    logic [OUTW-1:0]  loadVal;
    logic [PTW-y:0]   unusedBits;

    assign unusedBits = {reg_readyxSS, ctBuf[PTW-y-1:0]};

    // Start is edge-qualified so a level held across a whole run cannot retrigger from DONE.
    assign startReq   = reg_startxSS & encryption_startxSI;
    assign startPulse = startReq & ~startPrev & (state == IDLE || state == DONE);

    assign adPad = {adReg, 1'b1, {(ADW - l - 1){1'b0}}};
    assign ptPad = {ptReg, 1'b1, {(PTW - y - 1){1'b0}}};

    always_comb begin
        adBlk = '0;
        ptBlk = '0;
        for (int unsigned i = 0; i < ADBLK; i++)
            if (blk == 16'(i)) adBlk = adPad[ADW-1-64*i -: 64];
        for (int unsigned i = 0; i < PTBLK; i++)
            if (blk == 16'(i)) ptBlk = ptPad[PTW-1-64*i -: 64];
    end

    // p-round permutations use the last p of the 12 round constants.
    always_comb begin
        rcIdx = (state == INIT || state == FINAL) ? 4'(12 - a) + rnd : 4'(12 - b) + rnd;
        rc    = {4'd15 - rcIdx, rcIdx};
    end

    // Block absorption is folded into the first round of each block.
    always_comb begin
        roundIn = s;
        if (state == AD && rnd == 4'd0) roundIn[319:256] = s[319:256] ^ adBlk;
        if (state == PT && rnd == 4'd0) roundIn[319:256] = s[319:256] ^ ptBlk;
        roundOut = asconRound(roundIn, rc);
    end

    always_comb begin
        loadVal = '0;
        if (state == DONE) loadVal = {ctBuf[PTW-1 -: y], tagReg};
    end

    // Lane loading: first byte written ends up as the MSB.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            keyReg   <= '0;
            nonceReg <= '0;
            adReg    <= '0;
            ptReg    <= '0;
            keyCnt   <= '0;
            nonceCnt <= '0;
            adCnt    <= '0;
            ptCnt    <= '0;
        end else if (startPulse) begin
            keyCnt   <= '0;
            nonceCnt <= '0;
            adCnt    <= '0;
            ptCnt    <= '0;
        end else begin
            if (reg_inputxSS[0] && keyCnt < 16'(KEYN)) begin
                keyReg <= {keyReg[k-9:0], inputxSI[7:0]};
                keyCnt <= keyCnt + 16'd1;
            end
            if (reg_inputxSS[1] && nonceCnt < 16'(NONCEN)) begin
                nonceReg <= {nonceReg[119:0], inputxSI[15:8]};
                nonceCnt <= nonceCnt + 16'd1;
            end
            if (reg_inputxSS[2] && adCnt < 16'(ADN)) begin
                adReg <= {adReg[l-9:0], inputxSI[23:16]};
                adCnt <= adCnt + 16'd1;
            end
            if (reg_inputxSS[3] && ptCnt < 16'(PTN)) begin
                ptReg <= {ptReg[y-9:0], inputxSI[31:24]};
                ptCnt <= ptCnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state               <= IDLE;
            s                   <= '0;
            rnd                 <= '0;
            blk                 <= '0;
            ctBuf               <= '0;
            tagReg              <= '0;
            startPrev           <= 1'b0;
            encryption_readyxSO <= 1'b0;
        end else begin
            startPrev <= startReq;
            case (state)
                IDLE, DONE: begin
                    if (startPulse) begin
                        s                   <= {IV, keyReg, nonceReg};
                        rnd                 <= '0;
                        blk                 <= '0;
                        encryption_readyxSO <= 1'b0;
                        state               <= INIT;
                    end
                end
                INIT: begin
                    if (rnd == 4'(a - 1)) begin
                        s     <= roundOut ^ {{(320 - k){1'b0}}, keyReg};
                        rnd   <= '0;
                        state <= AD;
                    end else begin
                        s   <= roundOut;
                        rnd <= rnd + 4'd1;
                    end
                end
                AD: begin
                    if (rnd == 4'(b - 1)) begin
                        rnd <= '0;
                        if (blk == 16'(ADBLK - 1)) begin
                            s     <= roundOut ^ 320'd1;
                            blk   <= '0;
                            state <= PT;
                        end else begin
                            s   <= roundOut;
                            blk <= blk + 16'd1;
                        end
                    end else begin
                        s   <= roundOut;
                        rnd <= rnd + 4'd1;
                    end
                end
                PT: begin
                    if (rnd == 4'd0)
                        for (int unsigned i = 0; i < PTBLK; i++)
                            if (blk == 16'(i)) ctBuf[PTW-1-64*i -: 64] <= roundIn[319:256];
                    // Last block skips the permutation; the FINAL key injection is merged here.
                    if (blk == 16'(PTBLK - 1)) begin
                        s     <= roundIn ^ {{r{1'b0}}, keyReg, {(320 - r - k){1'b0}}};
                        rnd   <= '0;
                        state <= FINAL;
                    end else begin
                        s <= roundOut;
                        if (rnd == 4'(b - 1)) begin
                            rnd <= '0;
                            blk <= blk + 16'd1;
                        end else begin
                            rnd <= rnd + 4'd1;
                        end
                    end
                end
                FINAL: begin
                    s <= roundOut;
                    if (rnd == 4'(a - 1)) begin
                        tagReg              <= roundOut[127:0] ^ keyReg;
                        encryption_readyxSO <= 1'b1;
                        state               <= DONE;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outSr         <= '0;
            cipher_tagxSO <= '0;
        end else if (reg_outxSS) begin
            outSr         <= loadVal;
            cipher_tagxSO <= loadVal[OUTW-1 -: 8];
        end else begin
            outSr         <= outSr << 8;
            cipher_tagxSO <= outSr[OUTW-9 -: 8];
        end
    end

endmodule

// File: tb/tb_soc_encryption.sv
// tb_soc_encryption: directed bench for soc_encryption with an Ascon-128
// reference computed inside the bench (table-driven S-box).
module tb_soc_encryption;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  reg_inputxSS;
    logic [31:0] inputxSI;
    logic        reg_startxSS;
    logic        encryption_startxSI;
    logic        reg_readyxSS;
    logic        encryption_readyxSO;
    logic        reg_outxSS;
    logic [7:0]  cipher_tagxSO;

    int checks = 0;
    int failures = 0;

    localparam logic [127:0] KEY   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] NONCE = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [63:0]  ADV   = 64'h0001020304050607;
    localparam logic [63:0]  PT1   = 64'h0001020304050607;
    localparam logic [63:0]  PT2   = 64'h1011121314151617;

    soc_encryption #(.k(128), .r(64), .a(12), .b(6), .l(64), .y(64)) dut (
        .clk(clk),
        .rst(rst),
        .reg_inputxSS(reg_inputxSS),
        .inputxSI(inputxSI),
        .reg_startxSS(reg_startxSS),
        .encryption_startxSI(encryption_startxSI),
        .reg_readyxSS(reg_readyxSS),
        .encryption_readyxSO(encryption_readyxSO),
        .reg_outxSS(reg_outxSS),
        .cipher_tagxSO(cipher_tagxSO)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [4:0] sbox(input logic [4:0] v);
        case (v)
            5'd0:  return 5'h04;  5'd1:  return 5'h0b;  5'd2:  return 5'h1f;  5'd3:  return 5'h14;
            5'd4:  return 5'h1a;  5'd5:  return 5'h15;  5'd6:  return 5'h09;  5'd7:  return 5'h02;
            5'd8:  return 5'h1b;  5'd9:  return 5'h05;  5'd10: return 5'h08;  5'd11: return 5'h12;
            5'd12: return 5'h1d;  5'd13: return 5'h03;  5'd14: return 5'h06;  5'd15: return 5'h1c;
            5'd16: return 5'h1e;  5'd17: return 5'h13;  5'd18: return 5'h07;  5'd19: return 5'h0e;
            5'd20: return 5'h00;  5'd21: return 5'h0d;  5'd22: return 5'h11;  5'd23: return 5'h18;
            5'd24: return 5'h10;  5'd25: return 5'h0c;  5'd26: return 5'h01;  5'd27: return 5'h19;
            5'd28: return 5'h16;  5'd29: return 5'h0a;  5'd30: return 5'h0f;  default: return 5'h17;
        endcase
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [319:0] tbPerm(input logic [319:0] st, input int rounds);
        logic [63:0] x [5];
        logic [4:0]  col, o;
        int          j;
        for (int i = 0; i < 5; i++) x[i] = st[319-64*i -: 64];
        for (int rr = 0; rr < rounds; rr++) begin
            j = 12 - rounds + rr;
            x[2] = x[2] ^ 64'((15 - j) * 16 + j);
            for (int bt = 0; bt < 64; bt++) begin
                col = {x[0][bt], x[1][bt], x[2][bt], x[3][bt], x[4][bt]};
                o = sbox(col);
                x[0][bt] = o[4]; x[1][bt] = o[3]; x[2][bt] = o[2]; x[3][bt] = o[1]; x[4][bt] = o[0];
            end
            x[0] = x[0] ^ ror64(x[0], 19) ^ ror64(x[0], 28);
            x[1] = x[1] ^ ror64(x[1], 61) ^ ror64(x[1], 39);
            x[2] = x[2] ^ ror64(x[2], 1)  ^ ror64(x[2], 6);
            x[3] = x[3] ^ ror64(x[3], 10) ^ ror64(x[3], 17);
            x[4] = x[4] ^ ror64(x[4], 7)  ^ ror64(x[4], 41);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    // Ascon-128 for one full 8-byte AD block and one full 8-byte PT block: returns {CT, tag}.
    function automatic logic [191:0] tbEncrypt(input logic [127:0] key, input logic [127:0] nonce,
                                               input logic [63:0] ad, input logic [63:0] pt);
        logic [319:0] st;
        logic [63:0]  ct;
        st = {64'h80400c0600000000, key, nonce};
        st = tbPerm(st, 12);
        st[127:0] = st[127:0] ^ key;
        st[319:256] = st[319:256] ^ ad;
        st = tbPerm(st, 6);
        st[319:256] = st[319:256] ^ 64'h8000000000000000;
        st = tbPerm(st, 6);
        st[0] = ~st[0];
        st[319:256] = st[319:256] ^ pt;
        ct = st[319:256];
        st = tbPerm(st, 6);
        st[319:256] = st[319:256] ^ 64'h8000000000000000;
        st[255:128] = st[255:128] ^ key;
        st = tbPerm(st, 12);
        return {ct, st[127:0] ^ key};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic loadWords(input logic [3:0] lanes, input logic [127:0] key, input logic [127:0] nonce,
                             input logic [63:0] ad, input logic [63:0] pt);
        for (int i = 0; i < 16; i++) begin
            reg_inputxSS   = lanes;
            inputxSI[7:0]  = key[127-8*i -: 8];
            inputxSI[15:8] = nonce[127-8*i -: 8];
            if (i < 8) begin
                inputxSI[23:16] = ad[63-8*i -: 8];
                inputxSI[31:24] = pt[63-8*i -: 8];
            end else begin
                inputxSI[31:16] = 16'h0000;
            end
            tick;
        end
        reg_inputxSS = '0;
        inputxSI     = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst = 1'b0;
        repeat (3) tick;
        checks++;
        if (encryption_readyxSO !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: got %0b want 0", encryption_readyxSO);
        end
        checks++;
        if (cipher_tagxSO !== 8'h00) begin
            failures++;
            $display("FAIL reset_out: got %02h want 00", cipher_tagxSO);
        end
        rst = 1'b1;
        tick;
    endtask

    task automatic test_load;
        loadWords(4'hF, KEY, NONCE, ADV, PT1);
        checks++;
        if (dut.keyReg !== KEY) begin
            failures++;
            $display("FAIL load_key: got %032h want %032h", dut.keyReg, KEY);
        end
        checks++;
        if (dut.nonceReg !== NONCE) begin
            failures++;
            $display("FAIL load_nonce: got %032h want %032h", dut.nonceReg, NONCE);
        end
        checks++;
        if (dut.adReg !== ADV) begin
            failures++;
            $display("FAIL load_ad_pad_ignored: got %016h want %016h", dut.adReg, ADV);
        end
        checks++;
        if (dut.ptReg !== PT1) begin
            failures++;
            $display("FAIL load_pt_pad_ignored: got %016h want %016h", dut.ptReg, PT1);
        end
    endtask

    task automatic test_no_start;
        reg_startxSS        = 1'b0;
        encryption_startxSI = 1'b1;
        reg_readyxSS        = 1'b1;
        repeat (60) tick;
        encryption_startxSI = 1'b0;
        reg_readyxSS        = 1'b0;
        checks++;
        if (encryption_readyxSO !== 1'b0) begin
            failures++;
            $display("FAIL no_start_ready: got %0b want 0", encryption_readyxSO);
        end
        reg_outxSS = 1'b1;
        tick;
        checks++;
        if (cipher_tagxSO !== 8'h00) begin
            failures++;
            $display("FAIL out_before_done: got %02h want 00", cipher_tagxSO);
        end
        reg_outxSS = 1'b0;
        tick;
    endtask

    task automatic test_start_hold;
        int n;
        n = 0;
        reg_startxSS        = 1'b1;
        encryption_startxSI = 1'b1;
        while (n < 200 && encryption_readyxSO !== 1'b1) begin
            tick;
            n++;
            if (n == 4) begin
                reg_startxSS        = 1'b0;
                encryption_startxSI = 1'b0;
            end
        end
        reg_startxSS        = 1'b0;
        encryption_startxSI = 1'b0;
        checks++;
        if (n < 42 || n > 46) begin
            failures++;
            $display("FAIL start_latency: got %0d clocks want 42..46", n);
        end
        repeat (60) tick;
        checks++;
        if (encryption_readyxSO !== 1'b1) begin
            failures++;
            $display("FAIL single_run_ready_held: got %0b want 1", encryption_readyxSO);
        end
    endtask

    task automatic test_readout(input logic [191:0] exp, input string name);
        logic [191:0] v;
        v = exp;
        reg_outxSS = 1'b1;
        repeat (3) tick;
        reg_outxSS = 1'b0;
        checks++;
        if (cipher_tagxSO !== v[191:184]) begin
            failures++;
            $display("FAIL %s_byte0: got %02h want %02h", name, cipher_tagxSO, v[191:184]);
        end
        for (int j = 1; j < 24; j++) begin
            tick;
            checks++;
            if (cipher_tagxSO !== v[191-8*j -: 8]) begin
                failures++;
                $display("FAIL %s_byte%0d: got %02h want %02h", name, j, cipher_tagxSO, v[191-8*j -: 8]);
            end
        end
        for (int j = 0; j < 3; j++) begin
            tick;
            checks++;
            if (cipher_tagxSO !== 8'h00) begin
                failures++;
                $display("FAIL %s_tail%0d: got %02h want 00", name, j, cipher_tagxSO);
            end
        end
    endtask

    task automatic test_back_to_back;
        int n;
        loadWords(4'b1000, KEY, NONCE, ADV, PT2);
        checks++;
        if (dut.ptReg !== PT2) begin
            failures++;
            $display("FAIL reload_pt: got %016h want %016h", dut.ptReg, PT2);
        end
        reg_startxSS        = 1'b1;
        encryption_startxSI = 1'b1;
        tick;
        reg_startxSS        = 1'b0;
        encryption_startxSI = 1'b0;
        checks++;
        if (encryption_readyxSO !== 1'b0) begin
            failures++;
            $display("FAIL restart_ready_drop: got %0b want 0", encryption_readyxSO);
        end
        n = 1;
        while (n < 200 && encryption_readyxSO !== 1'b1) begin
            tick;
            n++;
        end
        checks++;
        if (n < 42 || n > 46) begin
            failures++;
            $display("FAIL restart_latency: got %0d clocks want 42..46", n);
        end
        test_readout(tbEncrypt(KEY, NONCE, ADV, PT2), "run2");
    endtask

    task automatic test_reset_midrun;
        // async clear of a DONE peripheral with a nonzero byte on the output
        reg_outxSS = 1'b1;
        tick;
        reg_outxSS = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (encryption_readyxSO !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_ready: got %0b want 0", encryption_readyxSO);
        end
        checks++;
        if (cipher_tagxSO !== 8'h00) begin
            failures++;
            $display("FAIL async_reset_out: got %02h want 00", cipher_tagxSO);
        end
        checks++;
        if (dut.keyReg !== 128'h0) begin
            failures++;
            $display("FAIL async_reset_key: got %032h want 0", dut.keyReg);
        end
        tick;
        rst = 1'b1;
        tick;
        // abort an in-flight run
        loadWords(4'hF, KEY, NONCE, ADV, PT1);
        reg_startxSS        = 1'b1;
        encryption_startxSI = 1'b1;
        tick;
        reg_startxSS        = 1'b0;
        encryption_startxSI = 1'b0;
        repeat (10) tick;
        rst = 1'b0;
        repeat (2) tick;
        rst = 1'b1;
        repeat (80) tick;
        checks++;
        if (encryption_readyxSO !== 1'b0) begin
            failures++;
            $display("FAIL midrun_abort_ready: got %0b want 0", encryption_readyxSO);
        end
        checks++;
        if (cipher_tagxSO !== 8'h00) begin
            failures++;
            $display("FAIL midrun_abort_out: got %02h want 00", cipher_tagxSO);
        end
    endtask

    initial begin
        rst                 = 1'b0;
        reg_inputxSS        = '0;
        inputxSI            = '0;
        reg_startxSS        = 1'b0;
        encryption_startxSI = 1'b0;
        reg_readyxSS        = 1'b0;
        reg_outxSS          = 1'b0;
        test_reset;
        test_load;
        test_no_start;
        test_start_hold;
        test_readout(tbEncrypt(KEY, NONCE, ADV, PT1), "run1");
        test_back_to_back;
        test_reset_midrun;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
